// File: rtl/ecsm_ctrl.sv
// Scalar-multiplication sequencer: left-to-right double-and-add over an external ECPA adder.
// Define ECSM_CT_EN for constant-time mode (DBL+ADD every bit, dummy ADD discarded).
module ecsm_ctrl #(
  parameter int W  = 256,
  parameter int KW = 256
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [KW-1:0] i_k,
  input  logic [W-1:0]  p,
  input  logic [W-1:0]  Xp,
  input  logic [W-1:0]  Yp,
  input  logic [W-1:0]  Zp,
  output logic [W-1:0]  X,
  output logic [W-1:0]  Y,
  output logic [W-1:0]  Z,
  output logic          o_inf,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pa_start,
  output logic [W-1:0]  o_pa_X1,
  output logic [W-1:0]  o_pa_Y1,
  output logic [W-1:0]  o_pa_Z1,
  output logic [W-1:0]  o_pa_X2,
  output logic [W-1:0]  o_pa_Y2,
  output logic [W-1:0]  o_pa_Z2,
  input  logic [W-1:0]  i_pa_X3,
  input  logic [W-1:0]  i_pa_Y3,
  input  logic [W-1:0]  i_pa_Z3,
  input  logic          i_pa_done
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(KW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL,
    S_ADD,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_reg;
  logic [KW-1:0] k_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  px_reg, py_reg, pz_reg;
  logic [W-1:0]  ax_reg, ay_reg, az_reg;

  logic k_bit;
  logic add_commit;
  logic dbl_then_add;
  logic acc_inf;
  logic p_unused;

  // The modulus is consumed by the ECPA datapath only.
  assign p_unused = ^p;
  assign k_bit    = k_reg[idx_reg];

`ifdef ECSM_CT_EN
  assign add_commit   = k_bit;
  assign dbl_then_add = 1'b1;
  assign acc_inf      = (az_reg == '0);
`else
  logic inf_reg;
  assign add_commit   = 1'b1;
  assign dbl_then_add = k_bit;
  assign acc_inf      = inf_reg | (az_reg == '0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= S_IDLE;
      k_reg      <= '0;
      idx_reg    <= IDX_MSB;
      px_reg     <= '0;
      py_reg     <= '0;
      pz_reg     <= '0;
      ax_reg     <= '0;
      ay_reg     <= W'(1);
      az_reg     <= '0;
`ifndef ECSM_CT_EN
      inf_reg    <= 1'b1;
`endif
      X          <= '0;
      Y          <= W'(1);
      Z          <= '0;
      o_inf      <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pa_start <= 1'b0;
      o_pa_X1    <= '0;
      o_pa_Y1    <= '0;
      o_pa_Z1    <= '0;
      o_pa_X2    <= '0;
      o_pa_Y2    <= '0;
      o_pa_Z2    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            k_reg     <= i_k;
            px_reg    <= Xp;
            py_reg    <= Yp;
            pz_reg    <= Zp;
            ax_reg    <= '0;
            ay_reg    <= W'(1);
            az_reg    <= '0;
`ifndef ECSM_CT_EN
            inf_reg   <= 1'b1;
`endif
            idx_reg   <= IDX_MSB;
            o_busy    <= 1'b1;
            state_reg <= S_SCAN;
          end
        end

        S_SCAN: begin
`ifdef ECSM_CT_EN
          state_reg <= S_DBL;
`else
          // While the accumulator is still infinity, leading bits cost no ECPA op.
          if (!inf_reg) begin
            state_reg <= S_DBL;
          end else begin
            if (k_bit) begin
              ax_reg  <= px_reg;
              ay_reg  <= py_reg;
              az_reg  <= pz_reg;
              inf_reg <= 1'b0;
            end
            if (idx_reg == '0) state_reg <= S_DONE;
            else               idx_reg   <= idx_reg - IW'(1);
          end
`endif
        end

        S_DBL, S_ADD: begin
          if (!o_pa_start) begin
            // A done still high from the previous op must clear before a new start.
            if (!i_pa_done) begin
              o_pa_start <= 1'b1;
              o_pa_X1    <= ax_reg;
              o_pa_Y1    <= ay_reg;
              o_pa_Z1    <= az_reg;
              o_pa_X2    <= (state_reg == S_DBL) ? ax_reg : px_reg;
              o_pa_Y2    <= (state_reg == S_DBL) ? ay_reg : py_reg;
              o_pa_Z2    <= (state_reg == S_DBL) ? az_reg : pz_reg;
            end
          end else if (i_pa_done) begin
            o_pa_start <= 1'b0;
            if ((state_reg == S_DBL) || add_commit) begin
              ax_reg <= i_pa_X3;
              ay_reg <= i_pa_Y3;
              az_reg <= i_pa_Z3;
            end
            state_reg <= ((state_reg == S_DBL) && dbl_then_add) ? S_ADD : S_GAP;
          end
        end

        S_GAP: begin
          if (!i_pa_done) begin
            if (idx_reg == '0) begin
              state_reg <= S_DONE;
            end else begin
              idx_reg   <= idx_reg - IW'(1);
              state_reg <= S_SCAN;
            end
          end
        end

        S_DONE: begin
          if (!o_done) begin
            X      <= ax_reg;
            Y      <= ay_reg;
            Z      <= az_reg;
            o_inf  <= acc_inf;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (!i_start) begin
            o_done    <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
